updown_counter_param: RTL and testbench

//  Parametrised up/down modulo counter. Successor to the fixed 4-bit up/down counter.
//  - Adds: WIDTH parameter, enable, synchronous clear and load, and asynchronous reset.
//  - Uses one shared count register for both directions.
//  - Adds a wrap-event counter.

---
 rtl/updown_counter_param.sv | 136 +++++++++++++
 tb/tb_updown_counter_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised up/down modulo counter with enable, synchronous clear/load and a wrap-event counter.
// Define UDCNT_SAT_EN to build the saturating variant instead of wrap/reload.
module updown_counter_param #(
   parameter int WIDTH = 4,
   parameter int CW    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   input  logic [WIDTH-1:0] up_max,
   input  logic [WIDTH-1:0] dn_max,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic [CW-1:0]    wrap_cnt
);

   localparam logic [WIDTH-1:0] Q_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] Q_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    W_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]    W_ONE  = {{(CW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;
   logic             tc_r;
   logic [CW-1:0]    wrap_cnt_r;

   logic [WIDTH-1:0] q_nxt_s;
   logic             tc_nxt_s;
   logic [CW-1:0]    wrap_nxt_s;

`ifdef UDCNT_SAT_EN
   // dn_max has no role once reload is replaced by saturation at zero.
   logic unused_dn_max_s;
   assign unused_dn_max_s = ^dn_max;

   // Next-state: clear > load > saturating count > hold.
   always_comb begin
      q_nxt_s    = q_r;
      tc_nxt_s   = 1'b0;
      wrap_nxt_s = wrap_cnt_r;
      if (clr) begin
         q_nxt_s    = Q_ZERO;
         wrap_nxt_s = W_ZERO;
      end else if (load) begin
         q_nxt_s = load_val;
      end else if (en) begin
         if (!dir) begin
            if (q_r >= up_max) begin
               q_nxt_s  = up_max;
               tc_nxt_s = 1'b1;
               // A q above up_max being pulled down counts as a fresh arrival.
               if (q_r != up_max) begin
                  wrap_nxt_s = wrap_cnt_r + W_ONE;
               end else begin
                  wrap_nxt_s = wrap_cnt_r;
               end
            end else if ((q_r + Q_ONE) == up_max) begin
               q_nxt_s    = up_max;
               tc_nxt_s   = 1'b1;
               wrap_nxt_s = wrap_cnt_r + W_ONE;
            end else begin
               q_nxt_s = q_r + Q_ONE;
            end
         end else begin
            if (q_r == Q_ZERO) begin
               q_nxt_s  = Q_ZERO;
               tc_nxt_s = 1'b1;
            end else if (q_r == Q_ONE) begin
               q_nxt_s    = Q_ZERO;
               tc_nxt_s   = 1'b1;
               wrap_nxt_s = wrap_cnt_r + W_ONE;
            end else begin
               q_nxt_s = q_r - Q_ONE;
            end
         end
      end else begin
         q_nxt_s = q_r;
      end
   end
`else
   // Next-state: clear > load > wrapping count > hold.
   always_comb begin
      q_nxt_s    = q_r;
      tc_nxt_s   = 1'b0;
      wrap_nxt_s = wrap_cnt_r;
      if (clr) begin
         q_nxt_s    = Q_ZERO;
         wrap_nxt_s = W_ZERO;
      end else if (load) begin
         q_nxt_s = load_val;
      end else if (en) begin
         if (!dir) begin
            // >= so that a q left above a lowered limit wraps instead of running away.
            if (q_r >= up_max) begin
               q_nxt_s    = Q_ZERO;
               tc_nxt_s   = 1'b1;
               wrap_nxt_s = wrap_cnt_r + W_ONE;
            end else begin
               q_nxt_s = q_r + Q_ONE;
            end
         end else begin
            if (q_r == Q_ZERO) begin
               q_nxt_s    = dn_max;
               tc_nxt_s   = 1'b1;
               wrap_nxt_s = wrap_cnt_r + W_ONE;
            end else begin
               q_nxt_s = q_r - Q_ONE;
            end
         end
      end else begin
         q_nxt_s = q_r;
      end
   end
`endif

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r        <= Q_ZERO;
         tc_r       <= 1'b0;
         wrap_cnt_r <= W_ZERO;
      end else begin
         q_r        <= q_nxt_s;
         tc_r       <= tc_nxt_s;
         wrap_cnt_r <= wrap_nxt_s;
      end
   end

   assign q        = q_r;
   assign tc       = tc_r;
   assign wrap_cnt = wrap_cnt_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench for updown_counter_param (WIDTH=4, CW=8).
// Builds the saturating checks when UDCNT_SAT_EN is defined, the wrap/reload checks otherwise.
module tb_updown_counter_param;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic       en;
   logic       dir;
   logic [3:0] up_max;
   logic [3:0] dn_max;
   logic [3:0] q;
   logic       tc;
   logic [7:0] wrap_cnt;

   int checks;
   int failures;

   updown_counter_param #(.WIDTH(4), .CW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .dir      (dir),
      .up_max   (up_max),
      .dn_max   (dn_max),
      .q        (q),
      .tc       (tc),
      .wrap_cnt (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag, input int exp_q, input int exp_tc);
      step();
      chk({tag, "_q"}, {28'd0, q}, exp_q);
      chk({tag, "_tc"}, {31'd0, tc}, exp_tc);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = 4'd0;
      en       = 1'b0;
      dir      = 1'b0;
      up_max   = 4'd5;
      dn_max   = 4'd0;
      #1;
      chk("rst_q", {28'd0, q}, 32'd0);
      chk("rst_tc", {31'd0, tc}, 32'd0);
      chk("rst_wrap", {24'd0, wrap_cnt}, 32'd0);
      step();
      step();
      rst_n = 1'b1;

`ifdef UDCNT_SAT_EN
      // Saturating up to 3, then down to 0.
      en = 1'b1; dir = 1'b0; up_max = 4'd3;
      step_chk("sat_up1", 1, 0);
      step_chk("sat_up2", 2, 0);
      step_chk("sat_up3", 3, 1);
      step_chk("sat_up4", 3, 1);
      step_chk("sat_up5", 3, 1);
      step_chk("sat_up6", 3, 1);
      chk("sat_up_wrap", {24'd0, wrap_cnt}, 32'd1);
      dir = 1'b1;
      step_chk("sat_dn1", 2, 0);
      step_chk("sat_dn2", 1, 0);
      step_chk("sat_dn3", 0, 1);
      step_chk("sat_dn4", 0, 1);
      chk("sat_dn_wrap", {24'd0, wrap_cnt}, 32'd2);
      load = 1'b1; load_val = 4'd12;
      step_chk("sat_ld", 12, 0);
      load = 1'b0; dir = 1'b0;
      step_chk("sat_force", 3, 1);
      chk("sat_force_wrap", {24'd0, wrap_cnt}, 32'd3);
      clr = 1'b1; load = 1'b1;
      step_chk("sat_clr", 0, 0);
      chk("sat_clr_wrap", {24'd0, wrap_cnt}, 32'd0);
      clr = 1'b0; load = 1'b0;
`else
      // Up count with up_max=5.
      en = 1'b1; dir = 1'b0; up_max = 4'd5;
      step_chk("up1", 1, 0);
      step_chk("up2", 2, 0);
      step_chk("up3", 3, 0);
      step_chk("up4", 4, 0);
      step_chk("up5", 5, 0);
      step_chk("up_wrap", 0, 1);
      step_chk("up7", 1, 0);
      chk("up_wrapcnt", {24'd0, wrap_cnt}, 32'd1);

      // Load 3 then down with reload 9.
      load = 1'b1; load_val = 4'd3;
      step_chk("ld3", 3, 0);
      load = 1'b0; dir = 1'b1; dn_max = 4'd9;
      step_chk("dn2", 2, 0);
      step_chk("dn1", 1, 0);
      step_chk("dn0", 0, 0);
      step_chk("dn_reload", 9, 1);
      step_chk("dn8", 8, 0);
      chk("dn_wrapcnt", {24'd0, wrap_cnt}, 32'd2);

      // Direction switches mid-count.
      load = 1'b1; load_val = 4'd2; dir = 1'b0;
      step_chk("ld2", 2, 0);
      load = 1'b0;
      step_chk("sw_up3", 3, 0);
      step_chk("sw_up4", 4, 0);
      dir = 1'b1;
      step_chk("sw_dn3", 3, 0);
      step_chk("sw_dn2", 2, 0);
      dir = 1'b0;
      step_chk("sw_up3b", 3, 0);
      step_chk("sw_up4b", 4, 0);
      step_chk("sw_up5", 5, 0);
      step_chk("sw_wrap", 0, 1);
      chk("sw_wrapcnt", {24'd0, wrap_cnt}, 32'd3);

      // Loaded value above up_max wraps on the next enabled edge.
      load = 1'b1; load_val = 4'd12;
      step_chk("ld12", 12, 0);
      load = 1'b0;
      step_chk("over_wrap", 0, 1);
      step_chk("over_next", 1, 0);
      chk("over_wrapcnt", {24'd0, wrap_cnt}, 32'd4);

      // Hold with en low.
      en = 1'b0;
      step_chk("hold", 1, 0);
      chk("hold_wrapcnt", {24'd0, wrap_cnt}, 32'd4);

      // Zero limits: tc every enabled cycle.
      en = 1'b1; up_max = 4'd0;
      step_chk("upmax0_a", 0, 1);
      step_chk("upmax0_b", 0, 1);
      dir = 1'b1; dn_max = 4'd0;
      step_chk("dnmax0", 0, 1);
      chk("zero_wrapcnt", {24'd0, wrap_cnt}, 32'd7);

      // clr beats load and en.
      dir = 1'b0; up_max = 4'd5; load = 1'b1; load_val = 4'd7;
      step_chk("ld7", 7, 0);
      clr = 1'b1;
      step_chk("clr", 0, 0);
      chk("clr_wrapcnt", {24'd0, wrap_cnt}, 32'd0);
      clr = 1'b0; load = 1'b0;

      // Async reset with all outputs non-zero.
      dir = 1'b1; dn_max = 4'd9;
      step_chk("pre_rst", 9, 1);
      chk("pre_rst_wrapcnt", {24'd0, wrap_cnt}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_q", {28'd0, q}, 32'd0);
      chk("async_tc", {31'd0, tc}, 32'd0);
      chk("async_wrap", {24'd0, wrap_cnt}, 32'd0);
      step();
      rst_n = 1'b1; dir = 1'b0;
      step_chk("resume", 1, 0);

      // wrap_cnt rolls over silently after 256 wraps.
      up_max = 4'd0;
      for (int i = 0; i < 256; i++) begin
         step();
      end
      chk("roll_wrapcnt", {24'd0, wrap_cnt}, 32'd0);
      chk("roll_tc", {31'd0, tc}, 32'd1);
      chk("roll_q", {28'd0, q}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
